// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES-256 block sequencer and its parent.
// Enumerates the sequencer states and the fixed core-wrapper encodings.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        KEYGEN  = 3'd1,
        KEYWAIT = 3'd2,
        LOAD    = 3'd3,
        RUN     = 3'd4,
        WAIT    = 3'd5,
        OUT     = 3'd6,
        FATAL   = 3'd7
    } aes_seq_state_e;

    localparam logic [2:0] AES_SEQ_KEY_LEN_256 = 3'b100;
    localparam logic [1:0] AES_SEQ_OP_FWD      = 2'b01;
    localparam logic [1:0] AES_SEQ_OP_INV      = 2'b10;

endpackage

// File: rtl/aes_block_sequencer.sv
// Mode controller for the AES-256 cipher core wrapper: streams N blocks one at a
// time through the core with ECB/CBC chaining, running decryption-key generation first.
//
//   state   | meaning
//   IDLE    | accept a command; nblocks=0 completes here
//   KEYGEN  | issue decryption-key generation to the core
//   KEYWAIT | drain and discard the key-generation result
//   LOAD    | accept one input block
//   RUN     | present the (chained) block to the core
//   WAIT    | capture the core result and update the chaining value
//   OUT     | offer the result downstream
//   FATAL   | core alert seen; left only by reset
module aes_block_sequencer
    import aes_seq_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,

    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic         cmd_dec_i,
    input  logic         cmd_cbc_i,
    input  logic [255:0] cmd_key_i,
    input  logic [127:0] cmd_iv_i,
    input  logic [15:0]  cmd_nblocks_i,

    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_data_i,

    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic         out_last_o,

    output logic         done_o,
    output logic         busy_o,
    output logic         err_o,

    output logic         core_in_valid_o,
    input  logic         core_in_ready_i,
    input  logic         core_out_valid_i,
    output logic         core_out_ready_o,
    output logic [1:0]   core_op_o,
    output logic [2:0]   core_key_len_o,
    output logic         core_crypt_o,
    output logic         core_dec_key_gen_o,
    output logic         core_prng_reseed_o,
    output logic [127:0] core_state_init_o,
    output logic [255:0] core_key_init_o,
    input  logic [127:0] core_state_i,
    input  logic         core_alert_i
);

    aes_seq_state_e state_q, state_d;

    logic [255:0] key_q;
    logic [127:0] chain_q;
    logic [127:0] blk_q;
    logic [127:0] res_q;
    logic [15:0]  cnt_q;
    logic         dec_q;
    logic         cbc_q;
    logic         done_q;
    logic         done_d;
    logic         rdy_q;

    logic         cmd_hs;
    logic         in_hs;
    logic         out_hs;
    logic         core_out_hs;

    assign cmd_hs      = cmd_valid_i & cmd_ready_o;
    assign in_hs       = in_valid_i & in_ready_o;
    assign out_hs      = out_valid_o & out_ready_i;
    assign core_out_hs = core_out_valid_i & core_out_ready_o;

    // rdy_q keeps cmd_ready_o low while reset is asserted and for the first edge after it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            rdy_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    if (cmd_nblocks_i == 16'd0) begin
                        done_d = 1'b1;
                    end else if (cmd_dec_i) begin
                        state_d = KEYGEN;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            KEYGEN:  if (core_in_ready_i)  state_d = KEYWAIT;
            KEYWAIT: if (core_out_valid_i) state_d = LOAD;
            LOAD:    if (in_valid_i)       state_d = RUN;
            RUN:     if (core_in_ready_i)  state_d = WAIT;
            WAIT:    if (core_out_valid_i) state_d = OUT;
            OUT: begin
                if (out_ready_i) begin
                    if (cnt_q == 16'd1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            FATAL:   state_d = FATAL;
            default: state_d = FATAL;
        endcase
        if (core_alert_i) begin
            state_d = FATAL;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        cmd_ready_o        = 1'b0;
        in_ready_o         = 1'b0;
        out_valid_o        = 1'b0;
        out_last_o         = 1'b0;
        core_in_valid_o    = 1'b0;
        core_out_ready_o   = 1'b0;
        core_op_o          = AES_SEQ_OP_FWD;
        core_crypt_o       = 1'b0;
        core_dec_key_gen_o = 1'b0;
        core_state_init_o  = '0;
        case (state_q)
            IDLE: cmd_ready_o = rdy_q;
            KEYGEN: begin
                core_in_valid_o    = 1'b1;
                core_crypt_o       = 1'b1;
                core_dec_key_gen_o = 1'b1;
            end
            KEYWAIT: core_out_ready_o = 1'b1;
            LOAD:    in_ready_o       = 1'b1;
            RUN: begin
                core_in_valid_o   = 1'b1;
                core_crypt_o      = 1'b1;
                core_op_o         = dec_q ? AES_SEQ_OP_INV : AES_SEQ_OP_FWD;
                core_state_init_o = (cbc_q && !dec_q) ? (blk_q ^ chain_q) : blk_q;
            end
            WAIT: core_out_ready_o = 1'b1;
            OUT: begin
                out_valid_o = 1'b1;
                out_last_o  = (cnt_q == 16'd1);
            end
            default: ;
        endcase
    end

    // Datapath registers: command capture, input block, result and chaining value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q   <= '0;
            chain_q <= '0;
            blk_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            cbc_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_hs) begin
                        key_q   <= cmd_key_i;
                        chain_q <= cmd_iv_i;
                        cnt_q   <= cmd_nblocks_i;
                        dec_q   <= cmd_dec_i;
                        cbc_q   <= cmd_cbc_i;
                    end
                end
                LOAD: if (in_hs) blk_q <= in_data_i;
                WAIT: begin
                    if (core_out_hs) begin
                        res_q <= (cbc_q && dec_q) ? (core_state_i ^ chain_q) : core_state_i;
                        if (cbc_q) begin
                            chain_q <= dec_q ? blk_q : core_state_i;
                        end
                    end
                end
                OUT: if (out_hs) cnt_q <= cnt_q - 16'd1;
                default: ;
            endcase
        end
    end

    assign out_data_o         = res_q;
    assign done_o             = done_q;
    assign busy_o             = (state_q != IDLE);
    assign err_o              = (state_q == FATAL);
    assign core_key_len_o     = AES_SEQ_KEY_LEN_256;
    assign core_prng_reseed_o = 1'b0;
    assign core_key_init_o    = key_q;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Bench for aes_block_sequencer. The cipher core is a stand-in keyed bijection whose
// inverse only works after decryption-key generation with the same key.
module tb_aes_block_sequencer;

    logic         clk_i;
    logic         rst_ni;
    logic         cmd_valid_i, cmd_ready_o, cmd_dec_i, cmd_cbc_i;
    logic [255:0] cmd_key_i;
    logic [127:0] cmd_iv_i;
    logic [15:0]  cmd_nblocks_i;
    logic         in_valid_i, in_ready_o;
    logic [127:0] in_data_i;
    logic         out_valid_o, out_ready_i, out_last_o;
    logic [127:0] out_data_o;
    logic         done_o, busy_o, err_o;
    logic         core_in_valid_o, core_in_ready_i, core_out_valid_i, core_out_ready_o;
    logic [1:0]   core_op_o;
    logic [2:0]   core_key_len_o;
    logic         core_crypt_o, core_dec_key_gen_o, core_prng_reseed_o;
    logic [127:0] core_state_init_o, core_state_i;
    logic [255:0] core_key_init_o;
    logic         core_alert_i;

    aes_block_sequencer dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_dec_i(cmd_dec_i),
        .cmd_cbc_i(cmd_cbc_i), .cmd_key_i(cmd_key_i), .cmd_iv_i(cmd_iv_i),
        .cmd_nblocks_i(cmd_nblocks_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_last_o(out_last_o),
        .done_o(done_o), .busy_o(busy_o), .err_o(err_o),
        .core_in_valid_o(core_in_valid_o), .core_in_ready_i(core_in_ready_i),
        .core_out_valid_i(core_out_valid_i), .core_out_ready_o(core_out_ready_o),
        .core_op_o(core_op_o), .core_key_len_o(core_key_len_o), .core_crypt_o(core_crypt_o),
        .core_dec_key_gen_o(core_dec_key_gen_o), .core_prng_reseed_o(core_prng_reseed_o),
        .core_state_init_o(core_state_init_o), .core_key_init_o(core_key_init_o),
        .core_state_i(core_state_i), .core_alert_i(core_alert_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_pass  = 0;
    int core_tx = 0;
    int kg_tx   = 0;

    logic [127:0] blk_in[$];
    logic [127:0] blk_out[$];
    logic [127:0] exp_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_to(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    function automatic logic [127:0] toy_enc(input logic [127:0] x, input logic [255:0] k);
        logic [127:0] t;
        t = x ^ k[127:0];
        return {t[114:0], t[127:115]} + k[255:128];
    endfunction

    function automatic logic [127:0] toy_dec(input logic [127:0] y, input logic [255:0] k);
        logic [127:0] t;
        t = y - k[255:128];
        return {t[12:0], t[127:13]} ^ k[127:0];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ECB/CBC from the mode definitions, applied to whatever is in blk_in
    function automatic void ref_model(input bit dec, input bit cbc,
                                      input logic [255:0] key, input logic [127:0] iv);
        logic [127:0] chain, p;
        chain = iv;
        exp_q.delete();
        foreach (blk_in[i]) begin
            if (!dec) begin
                p = toy_enc(cbc ? (blk_in[i] ^ chain) : blk_in[i], key);
                if (cbc) chain = p;
            end else begin
                p = toy_dec(blk_in[i], key);
                if (cbc) begin
                    p     = p ^ chain;
                    chain = blk_in[i];
                end
            end
            exp_q.push_back(p);
        end
    endfunction

    // Core stand-in: random accept delay and latency; garbage if misused
    int           cph, cdly, clat;
    logic [255:0] dk_key;
    logic [127:0] cres;

    always @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cph <= 0; cdly <= 0; clat <= 0;
            core_in_ready_i <= 1'b0; core_out_valid_i <= 1'b0; core_state_i <= '0;
            dk_key <= '0; cres <= '0;
        end else begin
            case (cph)
                0: begin
                    core_in_ready_i <= 1'b0;
                    if (core_in_valid_o) begin
                        if (cdly == 0) begin
                            core_in_ready_i <= 1'b1;
                            cph  <= 1;
                            clat <= int'($urandom_range(0, 4));
                            if (core_dec_key_gen_o) begin
                                dk_key <= (core_op_o == 2'b01 && core_crypt_o) ? core_key_init_o : ~core_key_init_o;
                                cres   <= ~core_state_init_o;
                            end else if (!core_crypt_o) begin
                                cres <= ~core_state_init_o;
                            end else if (core_op_o == 2'b01) begin
                                cres <= toy_enc(core_state_init_o, core_key_init_o);
                            end else if (core_op_o == 2'b10 && dk_key == core_key_init_o) begin
                                cres <= toy_dec(core_state_init_o, core_key_init_o);
                            end else begin
                                cres <= ~core_state_init_o;
                            end
                        end else begin
                            cdly <= cdly - 1;
                        end
                    end
                end
                1: begin
                    core_in_ready_i <= 1'b0;
                    if (clat == 0) begin
                        core_out_valid_i <= 1'b1;
                        core_state_i     <= cres;
                        cph              <= core_out_ready_o ? 3 : 2;
                    end else begin
                        clat <= clat - 1;
                    end
                end
                2: if (core_out_ready_o) cph <= 3;
                default: begin
                    core_out_valid_i <= 1'b0;
                    core_state_i     <= rnd128();
                    cph              <= 0;
                    cdly             <= int'($urandom_range(0, 3));
                end
            endcase
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni && core_in_valid_o && core_in_ready_i) begin
            core_tx <= core_tx + 1;
            if (core_dec_key_gen_o) kg_tx <= kg_tx + 1;
        end
    end

    task automatic send_cmd(input bit dec, input bit cbc, input logic [255:0] key,
                            input logic [127:0] iv, input int n, input string tag, output bit ok);
        int cyc;
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_dec_i = dec; cmd_cbc_i = cbc;
        cmd_key_i = key; cmd_iv_i = iv; cmd_nblocks_i = 16'(n);
        cyc = 0;
        while (!cmd_ready_o && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        ok = cmd_ready_o;
        if (ok) @(negedge clk_i);
        else fail_to({tag, ".cmd"});
        cmd_valid_i = 1'b0;
    endtask

    task automatic run_cmd(input bit dec, input bit cbc, input logic [255:0] key,
                           input logic [127:0] iv, input int stall_blk, input int exp_kg,
                           input string tag);
        int n, kg0, tx0, ii, oo, cyc, stall_cnt, stall_tx0, stall_tx1;
        bit ok, hs_in, stall_ok;
        logic [127:0] stall_ref;
        n = blk_in.size();
        ref_model(dec, cbc, key, iv);
        blk_out.delete();
        kg0 = kg_tx; tx0 = core_tx;
        stall_tx0 = 0; stall_tx1 = 0; stall_ref = '0;
        send_cmd(dec, cbc, key, iv, n, tag, ok);
        if (!ok) return;
        if (n == 0) begin
            chk({tag, ".done"}, done_o, 1'b1);
            chk({tag, ".in_ready"}, in_ready_o, 1'b0);
            @(negedge clk_i);
            chk({tag, ".done_off"}, done_o, 1'b0);
            chk({tag, ".core_tx"}, core_tx - tx0, 0);
            chk({tag, ".busy"}, busy_o, 1'b0);
            return;
        end
        ii = 0; oo = 0; cyc = 0; hs_in = 0; stall_cnt = 0; stall_ok = 1;
        while (oo < n && cyc < 2000) begin
            if (hs_in) begin
                in_valid_i = 1'b0;
                ii++;
                hs_in = 0;
            end
            if (ii < n && !in_valid_i && $urandom_range(0, 2) != 0) begin
                in_valid_i = 1'b1;
                in_data_i  = blk_in[ii];
            end
            if (oo == stall_blk && out_valid_o && stall_cnt < 20) begin
                if (stall_cnt == 0) begin
                    stall_ref = out_data_o;
                    stall_tx0 = core_tx;
                end
                if (out_data_o !== stall_ref || in_ready_o || core_in_valid_o) stall_ok = 0;
                if (stall_cnt == 19) stall_tx1 = core_tx;
                out_ready_i = 1'b0;
                stall_cnt++;
            end else begin
                out_ready_i = ($urandom_range(0, 3) != 0);
            end
            if (in_valid_i && in_ready_o) hs_in = 1;
            if (out_valid_o && out_ready_i) begin
                chk($sformatf("%s.data%0d", tag, oo), out_data_o, exp_q[oo]);
                chk($sformatf("%s.last%0d", tag, oo), out_last_o, (oo == n - 1));
                blk_out.push_back(out_data_o);
                oo++;
            end
            @(negedge clk_i);
            cyc++;
        end
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;
        if (oo < n) begin
            fail_to({tag, ".stream"});
            return;
        end
        chk({tag, ".done"}, done_o, 1'b1);
        @(negedge clk_i);
        chk({tag, ".done_off"}, done_o, 1'b0);
        chk({tag, ".busy"}, busy_o, 1'b0);
        chk({tag, ".keygens"}, kg_tx - kg0, exp_kg);
        chk({tag, ".core_tx"}, core_tx - tx0, n + exp_kg);
        if (stall_blk >= 0) begin
            chk({tag, ".stall_len"}, stall_cnt, 20);
            chk({tag, ".stall_stable"}, stall_ok, 1'b1);
            chk({tag, ".stall_core_tx"}, stall_tx1 - stall_tx0, 0);
        end
    endtask

    typedef struct {
        bit dec;
        bit cbc;
        int n;
        int stall_blk;
        int exp_kg;
    } vec_t;

    initial begin
        vec_t         vecs[8];
        logic [255:0] key;
        logic [127:0] iv;
        logic [127:0] pt_save[$];
        bit           ok, fatal_ok;
        int           cyc;

        vecs[0] = '{dec: 1'b0, cbc: 1'b0, n: 1, stall_blk: -1, exp_kg: 0};
        vecs[1] = '{dec: 1'b1, cbc: 1'b0, n: 1, stall_blk: -1, exp_kg: 1};
        vecs[2] = '{dec: 1'b0, cbc: 1'b1, n: 4, stall_blk: -1, exp_kg: 0};
        vecs[3] = '{dec: 1'b1, cbc: 1'b1, n: 4, stall_blk: -1, exp_kg: 1};
        vecs[4] = '{dec: 1'b0, cbc: 1'b1, n: 3, stall_blk: 1,  exp_kg: 0};
        vecs[5] = '{dec: 1'b1, cbc: 1'b0, n: 0, stall_blk: -1, exp_kg: 0};
        vecs[6] = '{dec: 1'b0, cbc: 1'b0, n: 5, stall_blk: -1, exp_kg: 0};
        vecs[7] = '{dec: 1'b1, cbc: 1'b1, n: 3, stall_blk: 1,  exp_kg: 1};

        rst_ni = 1'b0;
        cmd_valid_i = 1'b0; cmd_dec_i = 1'b0; cmd_cbc_i = 1'b0;
        cmd_key_i = '0; cmd_iv_i = '0; cmd_nblocks_i = '0;
        in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0; core_alert_i = 1'b0;
        repeat (3) @(negedge clk_i);

        chk("rst.cmd_ready", cmd_ready_o, 1'b0);
        chk("rst.in_ready", in_ready_o, 1'b0);
        chk("rst.out_valid", out_valid_o, 1'b0);
        chk("rst.done_busy_err", {done_o, busy_o, err_o}, 3'b000);
        chk("rst.core_hs", {core_in_valid_o, core_out_ready_o}, 2'b00);
        chk("rst.core_op", core_op_o, 2'b01);
        chk("rst.key_len", core_key_len_o, 3'b100);
        chk("rst.core_ctl", {core_crypt_o, core_dec_key_gen_o, core_prng_reseed_o}, 3'b000);
        chk("rst.out_data", out_data_o, 128'd0);
        chk("rst.key_init", core_key_init_o, 256'd0);

        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("idle.cmd_ready", cmd_ready_o, 1'b1);

        for (int v = 0; v < 8; v++) begin
            key = {rnd128(), rnd128()};
            iv  = rnd128();
            blk_in.delete();
            for (int b = 0; b < vecs[v].n; b++) blk_in.push_back(rnd128());
            run_cmd(vecs[v].dec, vecs[v].cbc, key, iv, vecs[v].stall_blk, vecs[v].exp_kg,
                    $sformatf("vec%0d", v));
        end

        // CBC round trip: decrypting the produced ciphertext must give back the plaintext
        key = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        iv  = 128'h000102030405060708090a0b0c0d0e0f;
        blk_in = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                   128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
        pt_save = blk_in;
        run_cmd(1'b0, 1'b1, key, iv, -1, 0, "cbc_enc");
        blk_in = blk_out;
        run_cmd(1'b1, 1'b1, key, iv, -1, 1, "cbc_dec");
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("roundtrip%0d", b), (b < blk_out.size()) ? blk_out[b] : 128'hx, pt_save[b]);
        end

        // Core alert while waiting on the core: FATAL until reset
        blk_in.delete();
        blk_in.push_back(rnd128());
        send_cmd(1'b0, 1'b0, {rnd128(), rnd128()}, rnd128(), 2, "alert", ok);
        in_valid_i = 1'b1;
        in_data_i  = blk_in[0];
        cyc = 0;
        while (!core_out_ready_o && cyc < 100) begin
            @(negedge clk_i);
            if (!in_ready_o) in_valid_i = 1'b0;
            cyc++;
        end
        in_valid_i = 1'b0;
        if (!core_out_ready_o) fail_to("alert.wait");
        core_alert_i = 1'b1;
        @(negedge clk_i);
        core_alert_i = 1'b0;
        cmd_valid_i  = 1'b1;
        out_ready_i  = 1'b1;
        fatal_ok = 1;
        for (int c = 0; c < 10; c++) begin
            if (!err_o || !busy_o || cmd_ready_o || in_ready_o || out_valid_o || done_o ||
                core_in_valid_o || core_out_ready_o) fatal_ok = 0;
            @(negedge clk_i);
        end
        chk("fatal.err", err_o, 1'b1);
        chk("fatal.hold", fatal_ok, 1'b1);
        cmd_valid_i = 1'b0;
        out_ready_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("fatal.reset_err", {err_o, busy_o}, 2'b00);
        rst_ni = 1'b1;
        @(negedge clk_i);

        blk_in.delete();
        blk_in.push_back(rnd128());
        blk_in.push_back(rnd128());
        run_cmd(1'b0, 1'b0, {rnd128(), rnd128()}, rnd128(), -1, 0, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
